fw_ip4_cfg_shift_ctrl: RTL and testbench

Sequences the DUT configuration shift chain for the fw_ip4 slot. On a start request it:
- latches a CFG_BITS-wide configuration image;
- shifts it MSB-first on fw_config_in with a divided fw_config_clk;
- captures the bits returned on fw_config_out;
- pulses fw_config_load.
Sits between the fw_ip4 op-code decode (execute / status_clear) and the DUT-side config pins.

---
 rtl/fw_ip4_cfg_shift_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_fw_ip4_cfg_shift_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_ip4_cfg_shift_ctrl.sv
// Config shift-chain sequencer for the fw_ip4 slot: shifts an image MSB-first, captures the chain return, pulses load.
// Optional readback check against the previously loaded image: define FW_IP4_CFG_READBACK_CHECK_EN.
module fw_ip4_cfg_shift_ctrl #(
   parameter int CFG_BITS = 64,
   parameter int CLK_HALF = 4,
   parameter int LOAD_CYC = 2
) (
   input  logic                          fw_clk,
   input  logic                          fw_rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          status_clear,
   input  logic [CFG_BITS-1:0]           cfg_wdata,
   output logic [CFG_BITS-1:0]           cfg_rdata,
   output logic                          busy,
   output logic                          done,
   output logic                          err_busy,
   output logic                          err_mismatch,
   output logic [$clog2(CFG_BITS+1)-1:0] bit_cnt,
   output logic                          fw_config_clk,
   output logic                          fw_config_in,
   output logic                          fw_config_load,
   input  logic                          fw_config_out
);

   localparam int CNT_W  = $clog2(CFG_BITS + 1);
   localparam int PH_MAX = (CLK_HALF > LOAD_CYC) ? CLK_HALF : LOAD_CYC;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   localparam logic [PH_W-1:0]  CH_LAST  = PH_W'(CLK_HALF - 1);
   localparam logic [PH_W-1:0]  LD_LAST  = PH_W'(LOAD_CYC - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CFG_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_LOAD,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CFG_BITS-1:0] sr_q, sr_d;
   logic [CFG_BITS-1:0] cap_q, cap_d;
   logic [CFG_BITS-1:0] rdata_d;
   logic [PH_W-1:0]     ph_q, ph_d;
   logic [CNT_W-1:0]    bit_cnt_d;
   logic                start_ok;
   logic                done_set;
   logic                err_busy_set;

   assign start_ok     = (state_q == ST_IDLE) && start && !abort;
   assign err_busy_set = (state_q != ST_IDLE) && start && !abort;

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cap_d     = cap_q;
      ph_d      = ph_q + PH_W'(1);
      bit_cnt_d = bit_cnt;
      rdata_d   = cfg_rdata;
      done_set  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            ph_d = '0;
            if (start_ok) begin
               sr_d      = cfg_wdata;
               bit_cnt_d = '0;
               state_d   = ST_LOW;
            end
         end
         ST_LOW: begin
            if (ph_q == CH_LAST) begin
               ph_d    = '0;
               state_d = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (ph_q == CH_LAST) begin
               ph_d      = '0;
               cap_d     = {cap_q[CFG_BITS-2:0], fw_config_out};
               sr_d      = {sr_q[CFG_BITS-2:0], 1'b0};
               bit_cnt_d = bit_cnt + CNT_W'(1);
               state_d   = (bit_cnt == BIT_LAST) ? ST_LOAD : ST_LOW;
            end
         end
         ST_LOAD: begin
            if (ph_q == LD_LAST) begin
               ph_d    = '0;
               rdata_d = cap_q;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ph_d     = '0;
            done_set = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            ph_d    = '0;
            state_d = ST_IDLE;
         end
      endcase

      // Abort freezes the datapath where it stands; only the sequencer returns home.
      if (abort && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         ph_d      = '0;
         sr_d      = sr_q;
         cap_d     = cap_q;
         bit_cnt_d = bit_cnt;
         rdata_d   = cfg_rdata;
         done_set  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge fw_clk or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         state_q        <= ST_IDLE;
         sr_q           <= '0;
         cap_q          <= '0;
         ph_q           <= '0;
         bit_cnt        <= '0;
         cfg_rdata      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_busy       <= 1'b0;
         fw_config_clk  <= 1'b0;
         fw_config_in   <= 1'b0;
         fw_config_load <= 1'b0;
      end else begin
         state_q        <= state_d;
         sr_q           <= sr_d;
         cap_q          <= cap_d;
         ph_q           <= ph_d;
         bit_cnt        <= bit_cnt_d;
         cfg_rdata      <= rdata_d;
         busy           <= (state_d != ST_IDLE);
         done           <= done_set | (done & ~status_clear);
         err_busy       <= err_busy_set | (err_busy & ~status_clear);
         // Pins are registered from the next state so they line up with the phase being entered.
         fw_config_clk  <= (state_d == ST_HIGH);
         fw_config_load <= (state_d == ST_LOAD);
         fw_config_in   <= ((state_d == ST_LOW) || (state_d == ST_HIGH)) & sr_d[CFG_BITS-1];
      end
   end

`ifdef FW_IP4_CFG_READBACK_CHECK_EN
   logic [CFG_BITS-1:0] img_q;
   logic [CFG_BITS-1:0] prev_img_q;
   logic                prev_valid_q;
   logic                mis_set;

   assign mis_set = done_set && prev_valid_q && (cap_q != prev_img_q);

   always_ff @(posedge fw_clk or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         img_q        <= '0;
         prev_img_q   <= '0;
         prev_valid_q <= 1'b0;
         err_mismatch <= 1'b0;
      end else begin
         if (start_ok) begin
            img_q <= cfg_wdata;
         end
         // Only completed operations become the reference for the next readback.
         if (done_set) begin
            prev_img_q   <= img_q;
            prev_valid_q <= 1'b1;
         end
         err_mismatch <= mis_set | (err_mismatch & ~status_clear);
      end
   end
`else
   assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_fw_ip4_cfg_shift_ctrl.sv
// Randomized bench for fw_ip4_cfg_shift_ctrl against an 8-bit chain model and a transaction-level reference.
module tb_fw_ip4_cfg_shift_ctrl;

   localparam int CB      = 8;
   localparam int CH      = 2;
   localparam int LC      = 2;
   localparam int LAT     = 1 + 2 * CH * CB + LC + 1;
   localparam int TIMEOUT = 400;

   logic          fw_clk       = 1'b0;
   logic          fw_rst_n     = 1'b0;
   logic          start        = 1'b0;
   logic          abort        = 1'b0;
   logic          status_clear = 1'b0;
   logic [CB-1:0] cfg_wdata    = '0;
   logic [CB-1:0] cfg_rdata;
   logic          busy, done, err_busy, err_mismatch;
   logic [3:0]    bit_cnt;
   logic          fw_config_clk, fw_config_in, fw_config_load, fw_config_out;

   int checks = 0;
   int errors = 0;

   // Chain model: returns its MSB, takes in the bit seen at the clock rise, shifts on the fall.
   logic [CB-1:0] chain          = '0;
   logic [CB-1:0] chain_preset   = '0;
   logic          chain_load_req = 1'b0;
   logic          cfg_clk_q      = 1'b0;
   logic          in_lat         = 1'b0;
   logic          obs_bits [0:4095];
   int            pulse_cnt  = 0;
   int            load_cnt   = 0;
   int            glitch_cnt = 0;

   // Transaction-level reference for the readback flag.
   logic [CB-1:0] m_prev  = '0;
   logic          m_valid = 1'b0;
   logic          m_mis   = 1'b0;

   assign fw_config_out = chain[CB-1];

   always #5 fw_clk = ~fw_clk;

   fw_ip4_cfg_shift_ctrl #(
      .CFG_BITS(CB),
      .CLK_HALF(CH),
      .LOAD_CYC(LC)
   ) dut (
      .fw_clk        (fw_clk),
      .fw_rst_n      (fw_rst_n),
      .start         (start),
      .abort         (abort),
      .status_clear  (status_clear),
      .cfg_wdata     (cfg_wdata),
      .cfg_rdata     (cfg_rdata),
      .busy          (busy),
      .done          (done),
      .err_busy      (err_busy),
      .err_mismatch  (err_mismatch),
      .bit_cnt       (bit_cnt),
      .fw_config_clk (fw_config_clk),
      .fw_config_in  (fw_config_in),
      .fw_config_load(fw_config_load),
      .fw_config_out (fw_config_out)
   );

   always @(posedge fw_clk) begin
      cfg_clk_q <= fw_config_clk;
      if (fw_config_load) load_cnt <= load_cnt + 1;
      if (!cfg_clk_q && fw_config_clk) begin
         in_lat              <= fw_config_in;
         obs_bits[pulse_cnt] <= fw_config_in;
         pulse_cnt           <= pulse_cnt + 1;
      end
      if (cfg_clk_q && fw_config_clk && (fw_config_in !== in_lat)) glitch_cnt <= glitch_cnt + 1;
      if (chain_load_req) chain <= chain_preset;
      else if (cfg_clk_q && !fw_config_clk) chain <= {chain[CB-2:0], in_lat};
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1);
   end

   task automatic preset_chain(input logic [CB-1:0] v);
      @(negedge fw_clk);
      chain_preset   = v;
      chain_load_req = 1'b1;
      @(negedge fw_clk);
      chain_load_req = 1'b0;
   endtask

   task automatic clear_status();
      @(negedge fw_clk);
      status_clear = 1'b1;
      @(negedge fw_clk);
      status_clear = 1'b0;
      m_mis = 1'b0;
   endtask

   task automatic run_op(input logic [CB-1:0] img, input logic [CB-1:0] preset, input int inject_at,
                         output int lat, output logic [CB-1:0] seen, output int pulses,
                         output int loads, output int glitches);
      int n0, l0, g0;
      bit injected;
      preset_chain(preset);
      n0 = pulse_cnt;
      l0 = load_cnt;
      g0 = glitch_cnt;
      @(negedge fw_clk);
      start     = 1'b1;
      cfg_wdata = img;
      @(negedge fw_clk);
      start     = 1'b0;
      cfg_wdata = CB'($urandom);
      lat       = 1;
      injected  = 1'b0;
      while (busy === 1'b1 && lat < TIMEOUT) begin
         if (inject_at >= 0 && !injected && int'(bit_cnt) == inject_at) begin
            start     = 1'b1;
            cfg_wdata = ~img;
            injected  = 1'b1;
         end
         @(negedge fw_clk);
         start = 1'b0;
         lat++;
      end
      seen = '0;
      for (int i = 0; i < CB; i++) seen[CB-1-i] = obs_bits[n0+i];
      pulses   = pulse_cnt - n0;
      loads    = load_cnt - l0;
      glitches = glitch_cnt - g0;
`ifdef FW_IP4_CFG_READBACK_CHECK_EN
      if (m_valid && preset != m_prev) m_mis = 1'b1;
      m_prev  = img;
      m_valid = 1'b1;
`endif
   endtask

   task automatic test_reset();
      #23;
      checks++; if ({cfg_rdata, bit_cnt, busy, done, err_busy, err_mismatch, fw_config_clk, fw_config_in, fw_config_load} !== '0) begin
         errors++; $display("FAIL reset_outputs got %h want 0", {cfg_rdata, bit_cnt, busy, done, err_busy, err_mismatch, fw_config_clk, fw_config_in, fw_config_load}); end
      @(negedge fw_clk);
      fw_rst_n = 1'b1;
      repeat (3) @(negedge fw_clk);
      checks++; if ({busy, fw_config_clk, fw_config_load, done} !== 4'b0) begin
         errors++; $display("FAIL idle_after_reset got %b want 0000", {busy, fw_config_clk, fw_config_load, done}); end
   endtask

   task automatic test_basic();
      int lat, pulses, loads, glitches;
      logic [CB-1:0] seen;
      run_op(8'hA5, 8'h3C, -1, lat, seen, pulses, loads, glitches);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
      checks++; if (seen !== 8'hA5) begin errors++; $display("FAIL basic_in_seq got %h want a5", seen); end
      checks++; if (pulses !== CB) begin errors++; $display("FAIL basic_pulses got %0d want %0d", pulses, CB); end
      checks++; if (loads !== LC) begin errors++; $display("FAIL basic_load_cycles got %0d want %0d", loads, LC); end
      checks++; if (glitches !== 0) begin errors++; $display("FAIL basic_in_stable got %0d want 0", glitches); end
      checks++; if (cfg_rdata !== 8'h3C) begin errors++; $display("FAIL basic_rdata got %h want 3c", cfg_rdata); end
      checks++; if ({done, busy, err_busy} !== 3'b100) begin errors++; $display("FAIL basic_flags got %b want 100", {done, busy, err_busy}); end
      checks++; if (bit_cnt !== 4'd8) begin errors++; $display("FAIL basic_bit_cnt got %0d want 8", bit_cnt); end
      checks++; if (err_mismatch !== m_mis) begin errors++; $display("FAIL basic_mismatch got %b want %b", err_mismatch, m_mis); end
   endtask

   task automatic test_readback();
      int lat, pulses, loads, glitches;
      logic [CB-1:0] seen, bad;
      run_op(8'hFF, 8'hA5, -1, lat, seen, pulses, loads, glitches);
      checks++; if (cfg_rdata !== 8'hA5) begin errors++; $display("FAIL rb_second_rdata got %h want a5", cfg_rdata); end
      checks++; if (err_mismatch !== m_mis) begin errors++; $display("FAIL rb_second_mismatch got %b want %b", err_mismatch, m_mis); end
      bad = 8'hFF ^ (8'h01 << $urandom_range(0, CB - 1));
      run_op(CB'($urandom), bad, -1, lat, seen, pulses, loads, glitches);
      checks++; if (cfg_rdata !== bad) begin errors++; $display("FAIL rb_corrupt_rdata got %h want %h", cfg_rdata, bad); end
      checks++; if (err_mismatch !== m_mis) begin errors++; $display("FAIL rb_corrupt_mismatch got %b want %b", err_mismatch, m_mis); end
   endtask

   task automatic test_random();
      int lat, pulses, loads, glitches;
      logic [CB-1:0] seen, img, preset;
      for (int n = 0; n < 6; n++) begin
         clear_status();
         img    = CB'($urandom);
         preset = ($urandom_range(0, 1) == 1) ? m_prev : CB'($urandom);
         run_op(img, preset, -1, lat, seen, pulses, loads, glitches);
         checks++; if (lat !== LAT) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, lat, LAT); end
         checks++; if (seen !== img) begin errors++; $display("FAIL rand%0d_in_seq got %h want %h", n, seen, img); end
         checks++; if (cfg_rdata !== preset) begin errors++; $display("FAIL rand%0d_rdata got %h want %h", n, cfg_rdata, preset); end
         checks++; if ({done, err_mismatch} !== {1'b1, m_mis}) begin
            errors++; $display("FAIL rand%0d_flags got %b want %b", n, {done, err_mismatch}, {1'b1, m_mis}); end
      end
   endtask

   task automatic test_err_busy();
      int lat, pulses, loads, glitches;
      logic [CB-1:0] seen, img, preset;
      clear_status();
      img    = CB'($urandom);
      preset = CB'($urandom);
      run_op(img, preset, 3, lat, seen, pulses, loads, glitches);
      checks++; if (err_busy !== 1'b1) begin errors++; $display("FAIL errbusy_set got %b want 1", err_busy); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL errbusy_latency got %0d want %0d", lat, LAT); end
      checks++; if (seen !== img) begin errors++; $display("FAIL errbusy_in_seq got %h want %h", seen, img); end
      checks++; if (cfg_rdata !== preset) begin errors++; $display("FAIL errbusy_rdata got %h want %h", cfg_rdata, preset); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL errbusy_done got %b want 1", done); end
      clear_status();
      checks++; if ({err_busy, done, err_mismatch} !== 3'b000) begin
         errors++; $display("FAIL status_clear got %b want 000", {err_busy, done, err_mismatch}); end
   endtask

   task automatic test_abort();
      logic [CB-1:0] rd0;
      int l0, cyc;
      clear_status();
      rd0 = cfg_rdata;
      preset_chain(CB'($urandom));
      l0 = load_cnt;
      @(negedge fw_clk);
      start     = 1'b1;
      cfg_wdata = CB'($urandom);
      @(negedge fw_clk);
      start = 1'b0;
      cyc   = 0;
      while (!(bit_cnt === 4'd4 && fw_config_clk === 1'b1) && cyc < TIMEOUT) begin
         @(negedge fw_clk);
         cyc++;
      end
      checks++; if (cyc >= TIMEOUT) begin errors++; $display("FAIL abort_reach_high got timeout want bit 5 high"); end
      abort = 1'b1;
      @(negedge fw_clk);
      abort = 1'b0;
      checks++; if ({busy, fw_config_clk, fw_config_in, fw_config_load} !== 4'b0) begin
         errors++; $display("FAIL abort_pins got %b want 0000", {busy, fw_config_clk, fw_config_in, fw_config_load}); end
      checks++; if (bit_cnt !== 4'd4) begin errors++; $display("FAIL abort_bit_cnt got %0d want 4", bit_cnt); end
      repeat (LAT) @(negedge fw_clk);
      checks++; if (load_cnt - l0 !== 0) begin errors++; $display("FAIL abort_no_load got %0d want 0", load_cnt - l0); end
      checks++; if (cfg_rdata !== rd0) begin errors++; $display("FAIL abort_rdata got %h want %h", cfg_rdata, rd0); end
      checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL abort_done got %b want 00", {done, busy}); end
   endtask

   task automatic test_start_abort_idle();
      int n0;
      bit saw_busy;
      n0 = pulse_cnt;
      saw_busy = 1'b0;
      @(negedge fw_clk);
      start     = 1'b1;
      abort     = 1'b1;
      cfg_wdata = CB'($urandom);
      @(negedge fw_clk);
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy !== 1'b0) saw_busy = 1'b1;
         @(negedge fw_clk);
      end
      checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL idle_abort_busy got 1 want 0"); end
      checks++; if (pulse_cnt - n0 !== 0) begin errors++; $display("FAIL idle_abort_pulses got %0d want 0", pulse_cnt - n0); end
      checks++; if (bit_cnt !== 4'd4) begin errors++; $display("FAIL idle_abort_bit_cnt got %0d want 4", bit_cnt); end
   endtask

   task automatic test_reset_in_load();
      int cyc, lat, pulses, loads, glitches;
      logic [CB-1:0] seen, img, preset;
      preset_chain(CB'($urandom));
      @(negedge fw_clk);
      start     = 1'b1;
      cfg_wdata = CB'($urandom);
      @(negedge fw_clk);
      start = 1'b0;
      cyc   = 0;
      while (fw_config_load !== 1'b1 && cyc < TIMEOUT) begin
         @(negedge fw_clk);
         cyc++;
      end
      checks++; if (cyc >= TIMEOUT) begin errors++; $display("FAIL rstload_reach_load got timeout want load"); end
      #2;
      fw_rst_n = 1'b0;
      #1;
      checks++; if ({fw_config_load, fw_config_clk, busy, done} !== 4'b0) begin
         errors++; $display("FAIL rstload_async got %b want 0000", {fw_config_load, fw_config_clk, busy, done}); end
      checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL rstload_bit_cnt got %0d want 0", bit_cnt); end
      m_prev  = '0;
      m_valid = 1'b0;
      m_mis   = 1'b0;
      @(negedge fw_clk);
      @(negedge fw_clk);
      fw_rst_n = 1'b1;
      img    = CB'($urandom);
      preset = CB'($urandom);
      run_op(img, preset, -1, lat, seen, pulses, loads, glitches);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rstload_latency got %0d want %0d", lat, LAT); end
      checks++; if (cfg_rdata !== preset) begin errors++; $display("FAIL rstload_rdata got %h want %h", cfg_rdata, preset); end
      checks++; if (seen !== img) begin errors++; $display("FAIL rstload_in_seq got %h want %h", seen, img); end
      checks++; if ({done, err_mismatch} !== {1'b1, m_mis}) begin
         errors++; $display("FAIL rstload_flags got %b want %b", {done, err_mismatch}, {1'b1, m_mis}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_readback();
      test_random();
      test_err_busy();
      test_abort();
      test_start_abort_idle();
      test_reset_in_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
